out_port_arb_mux: RTL and testbench

OUT_PORT_ARB_MUX -- requirements
Module: out_port_arb_mux

---
 rtl/out_port_arb_mux.sv | 109 ++++++++++
 tb/tb_out_port_arb_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/out_port_arb_mux.sv
// out_port_arb_mux: output-port arbiter and flit multiplexer for a wormhole router.
// Input ports compete for one output with round-robin arbitration on head flits.
// A multi-flit packet keeps the output locked until its tail flit has passed.
// The accepted flit is registered onto data_o one cycle after its grant.
//
// Ports:
//   clk, rst_n  rising-edge clock, asynchronous active-low reset
//   req_i       per-port flit valid
//   head_i      per-port head-flit marker
//   tail_i      per-port tail-flit marker (head&tail = single-flit packet)
//   data_i      per-port flits, port k at [k*DATA_W +: DATA_W]
//   gnt_o       one-hot pop strobe (combinational)
//   data_o      registered output flit
//   valid_o     data_o holds a valid flit
//   ready_i     downstream accepts data_o this cycle
//   sel_o       index of the current or last granted port
//   busy_o      a multi-flit packet holds the output
module out_port_arb_mux #(
  parameter int DATA_W  = 16,
  parameter int N_PORTS = 5,
  localparam int SEL_W  = (N_PORTS > 2) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_PORTS-1:0]        req_i,
  input  logic [N_PORTS-1:0]        head_i,
  input  logic [N_PORTS-1:0]        tail_i,
  input  logic [N_PORTS*DATA_W-1:0] data_i,
  output logic [N_PORTS-1:0]        gnt_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [SEL_W-1:0]          sel_o,
  output logic                      busy_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [SEL_W-1:0]   rr_ptr;
  logic               slot_free;
  logic               grant_any;
  logic [SEL_W-1:0]   grant_idx;
  logic [DATA_W-1:0]  grant_data;
  logic               grant_tail;
  logic [SEL_W-1:0]   cand;

  assign slot_free = !valid_o || ready_i;
  assign busy_o    = (state == LOCKED);

  always_comb begin
    gnt_o      = '0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    grant_tail = 1'b0;
    cand       = '0;
    if (rst_n && slot_free) begin
      if (state == IDLE) begin
        // Scan rr_ptr+1 .. rr_ptr+N_PORTS; the sum never exceeds 2*N_PORTS-1,
        // so a single conditional subtract performs the wrap.
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
          if (int'(rr_ptr) + int'(i) >= N_PORTS)
            cand = SEL_W'(int'(rr_ptr) + int'(i) - N_PORTS);
          else
            cand = SEL_W'(int'(rr_ptr) + int'(i));
          if (!grant_any && req_i[cand] && head_i[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end else if (req_i[sel_o]) begin
        grant_any = 1'b1;
        grant_idx = sel_o;
      end
    end
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      if (SEL_W'(k) == grant_idx) begin
        grant_data = data_i[k*DATA_W +: DATA_W];
        grant_tail = tail_i[k];
        gnt_o[k]   = grant_any;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= SEL_W'(N_PORTS - 1);
      valid_o <= 1'b0;
      data_o  <= '0;
      sel_o   <= '0;
    end else begin
      if (grant_any) begin
        data_o  <= grant_data;
        valid_o <= 1'b1;
        sel_o   <= grant_idx;
        rr_ptr  <= grant_idx;
        if (state == IDLE && !grant_tail)
          state <= LOCKED;
        else if (state == LOCKED && grant_tail)
          state <= IDLE;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_out_port_arb_mux.sv
// Directed testbench for out_port_arb_mux (DATA_W=16, N_PORTS=5).
module tb_out_port_arb_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_i, head_i, tail_i;
  logic [79:0] data_i;
  logic [4:0]  gnt_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  sel_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  out_port_arb_mux #(.DATA_W(16), .N_PORTS(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .data_i(data_i), .gnt_o(gnt_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .sel_o(sel_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int port, input logic [15:0] v);
    data_i[port*16 +: 16] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req_i = '0; head_i = '0; tail_i = '0; data_i = '0; ready_i = 1'b1;

    // Reset with a live request: outputs cleared, no grant.
    @(negedge clk);
    rst_n = 1'b0; req_i = 5'b00001; head_i = 5'b00001; tail_i = 5'b00001;
    #1;
    chk("rst_gnt",   32'(gnt_o),   32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_data",  32'(data_o),  32'h0);
    chk("rst_sel",   32'(sel_o),   32'h0);
    chk("rst_busy",  32'(busy_o),  32'h0);
    #1 rst_n = 1'b1;

    // Single flit from port 0.
    set_data(0, 16'hA5A5);
    #1;
    chk("a_gnt", 32'(gnt_o), 32'h01);
    tick();
    chk("a_valid", 32'(valid_o), 32'h1);
    chk("a_data",  32'(data_o),  32'hA5A5);
    chk("a_sel",   32'(sel_o),   32'h0);
    req_i = '0;
    #1;
    chk("a_gnt_idle", 32'(gnt_o), 32'h0);
    tick();
    chk("a_valid_clr", 32'(valid_o), 32'h0);
    chk("a_data_hold", 32'(data_o),  32'hA5A5);

    // All ports offer single-flit packets: round robin 0,1,2,3,4,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req_i = 5'b11111; head_i = 5'b11111; tail_i = 5'b11111;
    for (int k = 0; k < 5; k++) set_data(k, 16'h0B00 + 16'(k));
    #1;
    for (int j = 0; j < 7; j++) begin
      chk($sformatf("b_gnt%0d", j), 32'(gnt_o), 32'(5'b00001 << (j % 5)));
      chk($sformatf("b_busy%0d", j), 32'(busy_o), 32'h0);
      if (j > 0) chk($sformatf("b_data%0d", j), 32'(data_o), 32'h0B00 + 32'((j - 1) % 5));
      tick();
    end
    chk("b_data_last", 32'(data_o), 32'h0B01);
    req_i = '0; head_i = '0; tail_i = '0;
    #1;

    // Port 2 three-flit packet locks out port 1 (rr_ptr = 1 now).
    req_i = 5'b00110; head_i = 5'b00110; tail_i = 5'b00010;
    set_data(1, 16'h0111); set_data(2, 16'h0201);
    #1;
    chk("c_gnt_head", 32'(gnt_o), 32'h04);
    chk("c_busy0",    32'(busy_o), 32'h0);
    tick();
    chk("c_busy1", 32'(busy_o), 32'h1);
    chk("c_data1", 32'(data_o), 32'h0201);
    chk("c_sel1",  32'(sel_o),  32'h2);
    head_i[2] = 1'b0; set_data(2, 16'h0202);
    #1;
    chk("c_gnt_body", 32'(gnt_o), 32'h04);
    tick();
    chk("c_data2", 32'(data_o), 32'h0202);
    chk("c_busy2", 32'(busy_o), 32'h1);
    tail_i[2] = 1'b1; set_data(2, 16'h0203);
    #1;
    chk("c_gnt_tail", 32'(gnt_o), 32'h04);
    tick();
    chk("c_data3", 32'(data_o), 32'h0203);
    chk("c_busy3", 32'(busy_o), 32'h0);
    req_i[2] = 1'b0;
    #1;
    chk("c_gnt_p1", 32'(gnt_o), 32'h02);
    tick();
    chk("c_data4", 32'(data_o), 32'h0111);
    chk("c_sel4",  32'(sel_o),  32'h1);
    req_i = '0; head_i = '0; tail_i = '0;
    #1;
    chk("c_gnt_none", 32'(gnt_o), 32'h0);

    // Backpressure: 0x1234 held for three cycles, then port 4 flit loads.
    req_i = 5'b01000; head_i = 5'b01000; tail_i = 5'b01000;
    set_data(3, 16'h1234);
    #1;
    chk("d_gnt3", 32'(gnt_o), 32'h08);
    tick();
    ready_i = 1'b0;
    req_i = 5'b10000; head_i = 5'b10000; tail_i = 5'b10000;
    set_data(4, 16'h5678);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("d_stall_gnt%0d", j),   32'(gnt_o),   32'h0);
      chk($sformatf("d_stall_data%0d", j),  32'(data_o),  32'h1234);
      chk($sformatf("d_stall_valid%0d", j), 32'(valid_o), 32'h1);
      tick();
    end
    ready_i = 1'b1;
    #1;
    chk("d_gnt4", 32'(gnt_o), 32'h10);
    tick();
    chk("d_data4",  32'(data_o),  32'h5678);
    chk("d_valid4", 32'(valid_o), 32'h1);
    chk("d_sel4",   32'(sel_o),   32'h4);
    req_i = '0; head_i = '0; tail_i = '0;
    #1;
    chk("d_gnt_none", 32'(gnt_o), 32'h0);
    tick();
    chk("d_valid_clr", 32'(valid_o), 32'h0);
    chk("d_data_hold", 32'(data_o),  32'h5678);

    // Port 3 locks, stalls without timeout, then reset mid-packet.
    req_i = 5'b01000; head_i = 5'b01000; tail_i = 5'b00000;
    set_data(3, 16'h0301);
    #1;
    chk("e_gnt3", 32'(gnt_o), 32'h08);
    tick();
    chk("e_busy", 32'(busy_o), 32'h1);
    chk("e_data", 32'(data_o), 32'h0301);
    req_i = 5'b00001; head_i = 5'b00001; tail_i = 5'b00001;
    set_data(0, 16'h0A0A);
    #1;
    chk("e_blocked", 32'(gnt_o), 32'h0);
    tick();
    chk("e_wait_busy",  32'(busy_o),  32'h1);
    chk("e_wait_valid", 32'(valid_o), 32'h0);
    req_i = 5'b01001; head_i = 5'b00001; set_data(3, 16'h0302);
    #1;
    chk("e_gnt_body", 32'(gnt_o), 32'h08);
    tick();
    chk("e_valid_body", 32'(valid_o), 32'h1);
    chk("e_data_body",  32'(data_o),  32'h0302);
    rst_n = 1'b0;
    #1;
    chk("e_rst_valid", 32'(valid_o), 32'h0);
    chk("e_rst_busy",  32'(busy_o),  32'h0);
    chk("e_rst_data",  32'(data_o),  32'h0);
    chk("e_rst_gnt",   32'(gnt_o),   32'h0);
    #1 rst_n = 1'b1;
    req_i = 5'b01001; head_i = 5'b01001; tail_i = 5'b01001;
    #1;
    chk("e_gnt_p0", 32'(gnt_o), 32'h01);
    tick();
    chk("e_data_p0", 32'(data_o), 32'h0A0A);
    chk("e_sel_p0",  32'(sel_o),  32'h0);
    req_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
